// File: rtl/alu_step_ctrl.sv
// Pushbutton-stepped operand/operation loader for a downstream ALU datapath.
// A debounced key press walks A -> B -> OP -> SHOW and strobes the matching load.
module alu_step_ctrl #(
    parameter logic [19:0] DB_CYCLES = 20'd500000,
    parameter int unsigned SETTLE    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key,
    input  logic [31:0] sw,
    output logic [31:0] data,
    output logic [3:0]  op,
    output logic        ld_a,
    output logic        ld_b,
    output logic        ld_f,
    output logic [1:0]  stage,
    output logic        busy
);

    localparam int unsigned CW = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE);
    localparam logic [CW-1:0] CNT_ONE   = CW'(32'd1);
    localparam logic [19:0]   DB_LAST   = DB_CYCLES - 20'd1;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_OP   = 2'd2,
        S_SHOW = 2'd3
    } state_t;

    logic          key_meta_r;
    logic          key_sync_r;
    logic          db_level_r;
    logic          db_prev_r;
    logic [19:0]   db_cnt_r;
    logic          press_s;

    state_t        state_r;
    state_t        next_state_s;
    logic [31:0]   data_r;
    logic [31:0]   next_data_s;
    logic [3:0]    op_r;
    logic [3:0]    next_op_s;
    logic          ld_a_r;
    logic          next_ld_a_s;
    logic          ld_b_r;
    logic          next_ld_b_s;
    logic          ld_f_r;
    logic          next_ld_f_s;
    logic          busy_r;
    logic          next_busy_s;
    logic [CW-1:0] settle_cnt_r;
    logic [CW-1:0] next_settle_cnt_s;

    // Two-flop synchronizer for the asynchronous key.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_meta_r <= 1'b0;
            key_sync_r <= 1'b0;
        end else begin
            key_meta_r <= key;
            key_sync_r <= key_meta_r;
        end
    end

    // Debounce: the level follows the synchronized key only after DB_CYCLES unbroken differing cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_level_r <= 1'b0;
            db_prev_r  <= 1'b0;
            db_cnt_r   <= 20'd0;
        end else begin
            db_prev_r <= db_level_r;
            if (key_sync_r != db_level_r) begin
                if (db_cnt_r == DB_LAST) begin
                    db_level_r <= key_sync_r;
                    db_cnt_r   <= 20'd0;
                end else begin
                    db_cnt_r <= db_cnt_r + 20'd1;
                end
            end else begin
                db_cnt_r <= 20'd0;
            end
        end
    end

    assign press_s = db_level_r & ~db_prev_r;

    // Step sequencer and settle countdown: computes the next value of every registered output.
    always_comb begin
        next_state_s      = state_r;
        next_data_s       = data_r;
        next_op_s         = op_r;
        next_ld_a_s       = 1'b0;
        next_ld_b_s       = 1'b0;
        next_ld_f_s       = 1'b0;
        next_busy_s       = busy_r;
        next_settle_cnt_s = settle_cnt_r;

        // busy implies a nonzero count, so the decrement never wraps
        if (busy_r) begin
            if (settle_cnt_r == CNT_ONE) begin
                next_ld_f_s       = 1'b1;
                next_busy_s       = 1'b0;
                next_settle_cnt_s = '0;
            end else begin
                next_settle_cnt_s = settle_cnt_r - CNT_ONE;
            end
        end else begin
            next_settle_cnt_s = '0;
        end

        case (state_r)
            S_A: begin
                if (press_s) begin
                    next_data_s  = sw;
                    next_ld_a_s  = 1'b1;
                    next_state_s = S_B;
                end else begin
                    next_state_s = S_A;
                end
            end
            S_B: begin
                if (press_s) begin
                    next_data_s  = sw;
                    next_ld_b_s  = 1'b1;
                    next_state_s = S_OP;
                end else begin
                    next_state_s = S_B;
                end
            end
            S_OP: begin
                if (press_s) begin
                    next_op_s         = sw[31:28];
                    next_busy_s       = 1'b1;
                    next_settle_cnt_s = SETTLE_LD;
                    next_state_s      = S_SHOW;
                end else begin
                    next_state_s = S_OP;
                end
            end
            S_SHOW: begin
                // presses during the countdown or on the capture cycle are dropped
                if (press_s && !busy_r && !ld_f_r) begin
                    next_state_s = S_A;
                end else begin
                    next_state_s = S_SHOW;
                end
            end
            default: begin
                next_state_s = S_A;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= S_A;
            data_r       <= 32'd0;
            op_r         <= 4'd0;
            ld_a_r       <= 1'b0;
            ld_b_r       <= 1'b0;
            ld_f_r       <= 1'b0;
            busy_r       <= 1'b0;
            settle_cnt_r <= '0;
        end else begin
            state_r      <= next_state_s;
            data_r       <= next_data_s;
            op_r         <= next_op_s;
            ld_a_r       <= next_ld_a_s;
            ld_b_r       <= next_ld_b_s;
            ld_f_r       <= next_ld_f_s;
            busy_r       <= next_busy_s;
            settle_cnt_r <= next_settle_cnt_s;
        end
    end

    assign data  = data_r;
    assign op    = op_r;
    assign ld_a  = ld_a_r;
    assign ld_b  = ld_b_r;
    assign ld_f  = ld_f_r;
    assign stage = state_r;
    assign busy  = busy_r;

endmodule

// File: tb/tb_alu_step_ctrl.sv
// Directed bench for alu_step_ctrl: a short-settle instance for sequencing and debounce,
// and a long-settle instance to land presses inside the countdown and on the capture cycle.
module tb_alu_step_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        key;
    logic [31:0] sw;
    logic [31:0] data;
    logic [3:0]  op;
    logic        ld_a, ld_b, ld_f, busy;
    logic [1:0]  stage;

    logic        key2;
    logic [31:0] sw2;
    logic [31:0] data2;
    logic [3:0]  op2;
    logic        ld_a2, ld_b2, ld_f2, busy2;
    logic [1:0]  stage2;

    int n_cmp  = 0;
    int n_fail = 0;
    int cnt_a  = 0;
    int cnt_b  = 0;
    int cnt_f  = 0;

    logic        p_rst = 1'b1;
    logic        p_ld_a = 1'b0, p_ld_b = 1'b0, p_ld_f = 1'b0;
    logic [31:0] p_data = 32'd0;
    logic [3:0]  p_op = 4'd0;
    logic [1:0]  p_stage = 2'd0;

    alu_step_ctrl #(.DB_CYCLES(20'd4), .SETTLE(2)) u_dut (
        .clk(clk), .rst(rst), .key(key), .sw(sw), .data(data), .op(op),
        .ld_a(ld_a), .ld_b(ld_b), .ld_f(ld_f), .stage(stage), .busy(busy)
    );

    alu_step_ctrl #(.DB_CYCLES(20'd2), .SETTLE(12)) u_dut2 (
        .clk(clk), .rst(rst), .key(key2), .sw(sw2), .data(data2), .op(op2),
        .ld_a(ld_a2), .ld_b(ld_b2), .ld_f(ld_f2), .stage(stage2), .busy(busy2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Per-cycle invariants on the short-settle instance plus strobe tallies.
    always @(negedge clk) begin
        if (!rst && !p_rst) begin
            check("excl", 64'($countones({ld_a, ld_b, ld_f}) <= 1), 64'd1);
            check("one_cycle", 64'((ld_a && p_ld_a) || (ld_b && p_ld_b) || (ld_f && p_ld_f)), 64'd0);
            check("data_hold", 64'((data === p_data) || ld_a || ld_b), 64'd1);
            check("op_hold", 64'((op === p_op) || (stage == 2'd3 && p_stage == 2'd2)), 64'd1);
            check("excl2", 64'($countones({ld_a2, ld_b2, ld_f2}) <= 1), 64'd1);
        end
        if (ld_a && !p_ld_a) cnt_a++;
        if (ld_b && !p_ld_b) cnt_b++;
        if (ld_f && !p_ld_f) cnt_f++;
        p_rst   = rst;
        p_ld_a  = ld_a;
        p_ld_b  = ld_b;
        p_ld_f  = ld_f;
        p_data  = data;
        p_op    = op;
        p_stage = stage;
    end

    initial begin
        rst = 1'b1; key = 1'b0; sw = 32'd0; key2 = 1'b0; sw2 = 32'd0;
        tick(3);
        check("reset_outs", {22'd0, data, op, ld_a, ld_b, ld_f, stage, busy}, 64'd0);
        rst = 1'b0;
        tick(2);

        // clean full sequence
        sw = 32'h0000_0005; key = 1'b1;
        tick(6);
        check("a_not_early", {63'd0, ld_a}, 64'd0);
        tick(1);
        check("a_ld", {63'd0, ld_a}, 64'd1);
        check("a_data", {32'd0, data}, 64'h5);
        check("a_stage", {62'd0, stage}, 64'd1);
        tick(1);
        check("a_ld_drop", {63'd0, ld_a}, 64'd0);
        key = 1'b0; tick(8);

        sw = 32'h0000_0003; key = 1'b1;
        tick(7);
        check("b_ld", {63'd0, ld_b}, 64'd1);
        check("b_data", {32'd0, data}, 64'h3);
        check("b_stage", {62'd0, stage}, 64'd2);
        key = 1'b0; tick(8);

        sw = 32'h1000_0000; key = 1'b1;
        tick(7);
        check("op_stage", {62'd0, stage}, 64'd3);
        check("op_val", {60'd0, op}, 64'd1);
        check("op_busy", {63'd0, busy}, 64'd1);
        check("op_data_hold", {32'd0, data}, 64'h3);
        tick(1);
        check("f_not_early", {62'd0, ld_f, busy}, 64'b01);
        tick(1);
        check("f_pulse", {62'd0, ld_f, busy}, 64'b10);
        tick(1);
        check("f_drop", {63'd0, ld_f}, 64'd0);
        check("f_count", 64'(cnt_f), 64'd1);
        key = 1'b0; tick(8);

        // show -> wait A with no strobe, data/op hold
        sw = 32'hFFFF_FFFF; key = 1'b1;
        tick(7);
        check("show_stage", {62'd0, stage}, 64'd0);
        check("show_hold", {28'd0, data, op}, {28'd0, 32'h3, 4'd1});
        check("show_counts", {48'd0, 16'(cnt_a), 16'(cnt_b)}, {48'd0, 16'd1, 16'd1});
        check("show_fcount", 64'(cnt_f), 64'd1);
        key = 1'b0; tick(8);

        // bounce for 20 cycles then hold high
        sw = 32'h0000_00AA;
        for (int i = 0; i < 10; i++) begin
            key = ~key;
            tick(2);
        end
        key = 1'b1;
        tick(6);
        check("bounce_early", {61'd0, ld_a, stage}, 64'd0);
        tick(1);
        check("bounce_ld", {63'd0, ld_a}, 64'd1);
        check("bounce_data", {32'd0, data}, 64'hAA);
        tick(4);
        check("bounce_single", 64'(cnt_a), 64'd2);
        key = 1'b0; tick(8);

        // 3-cycle glitch is filtered
        key = 1'b1; tick(3); key = 1'b0; tick(10);
        check("glitch_stage", {62'd0, stage}, 64'd1);
        check("glitch_nob", 64'(cnt_b), 64'd1);

        sw = 32'h0000_0007; key = 1'b1;
        tick(7);
        check("b2_ld", {29'd0, ld_b, data}, {29'd0, 1'b1, 32'h7});
        key = 1'b0; tick(8);

        // reset during settle, key held through reset release
        sw = 32'h5000_0000; key = 1'b1;
        tick(7);
        check("rs_pre", {58'd0, stage, busy, op[2:0]}, {58'd0, 2'd3, 1'b1, 3'd5});
        rst = 1'b1;
        tick(1);
        check("rs_outs", {22'd0, data, op, ld_a, ld_b, ld_f, stage, busy}, 64'd0);
        rst = 1'b0;
        tick(6);
        check("rs_held_early", {61'd0, ld_a, stage}, 64'd0);
        tick(1);
        check("rs_held_ld", {63'd0, ld_a}, 64'd1);
        check("rs_held_data", {32'd0, data}, 64'h5000_0000);
        tick(4);
        check("rs_no_ldf", 64'(cnt_f), 64'd1);
        key = 1'b0;

        // long settle: press during countdown is discarded
        sw2 = 32'h1; key2 = 1'b1; tick(5);
        check("d2_a", {30'd0, stage2, data2}, {30'd0, 2'd1, 32'h1});
        key2 = 1'b0; tick(4);
        sw2 = 32'h2; key2 = 1'b1; tick(5);
        check("d2_b", {30'd0, stage2, data2}, {30'd0, 2'd2, 32'h2});
        key2 = 1'b0; tick(4);
        sw2 = 32'h3000_0000; key2 = 1'b1; tick(5);
        check("d2_op", {57'd0, stage2, busy2, op2}, {57'd0, 2'd3, 1'b1, 4'd3});
        key2 = 1'b0; tick(4);
        key2 = 1'b1; tick(5);
        check("d2_busy_ignore", {28'd0, stage2, busy2, ld_f2, data2}, {28'd0, 2'd3, 1'b1, 1'b0, 32'h2});
        tick(3);
        check("d2_ldf", {62'd0, ld_f2, busy2}, 64'b10);
        tick(1);
        check("d2_after_ldf", {61'd0, ld_f2, stage2}, {61'd0, 1'b0, 2'd3});
        key2 = 1'b0; tick(4);
        key2 = 1'b1; tick(5);
        check("d2_back_to_a", {58'd0, stage2, op2}, {58'd0, 2'd0, 4'd3});

        // long settle: press landing on the capture cycle is discarded
        key2 = 1'b0; tick(4);
        sw2 = 32'h11; key2 = 1'b1; tick(5);
        check("d2_a2", {62'd0, stage2}, 64'd1);
        key2 = 1'b0; tick(4);
        sw2 = 32'h22; key2 = 1'b1; tick(5);
        check("d2_b2", {62'd0, stage2}, 64'd2);
        key2 = 1'b0; tick(4);
        sw2 = 32'h4000_0000; key2 = 1'b1; tick(5);
        check("d2_op2", {58'd0, stage2, op2}, {58'd0, 2'd3, 4'd4});
        key2 = 1'b0; tick(8);
        key2 = 1'b1; tick(4);
        check("d2_coinc_ldf", {63'd0, ld_f2}, 64'd1);
        tick(1);
        check("d2_coinc_ignore", {61'd0, busy2, stage2}, {61'd0, 1'b0, 2'd3});
        key2 = 1'b0; tick(4);
        key2 = 1'b1; tick(5);
        check("d2_final", {62'd0, stage2}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_step_ctrl.md
ALU_STEP_CTRL -- requirements
Module: alu_step_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 20'd500000, consecutive stable key cycles required to accept a debounced level change (minimum 2).
REQ-002 Parameter SETTLE, default 3, cycles from operation latch to result-capture strobe (minimum 1).
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 key  input  1  raw pushbutton, active-high, asynchronous to clk, bouncy.
REQ-006 sw  input  32  switch bank; operand source; sw[31:28] is the operation code.
REQ-007 data  output  32  registered operand for the downstream A/B registers.
REQ-008 op  output  4  registered ALU operation code.
REQ-009 ld_a  output  1  one-cycle load strobe for operand register A.
REQ-010 ld_b  output  1  one-cycle load strobe for operand register B.
REQ-011 ld_f  output  1  one-cycle capture strobe for the result and flag registers.
REQ-012 stage  output  2  current step, for LEDs: 0=wait A, 1=wait B, 2=wait OP, 3=show.
REQ-013 busy  output  1  high while a capture is pending (settle countdown).

Function
REQ-014 key SHALL pass through a two-flop synchronizer before any other use.
REQ-015 Debounced level SHALL change only after the synchronized key differs from it for DB_CYCLES consecutive cycles; any interruption SHALL restart the count from zero.
REQ-016 A press event SHALL be a single-cycle pulse on the debounced level 0->1 transition; release SHALL generate no event.
REQ-017 The FSM SHALL have states S_A, S_B, S_OP, S_SHOW, encoded as stage 0..3.
REQ-018 Press in S_A at cycle t: at t+1, data = sw sampled at t, ld_a = 1 for exactly one cycle, stage = 1.
REQ-019 Press in S_B at cycle t: at t+1, data = sw sampled at t, ld_b = 1 for one cycle, stage = 2.
REQ-020 Press in S_OP at cycle t: at t+1, op = sw[31:28] sampled at t, busy = 1, stage = 3; ld_f SHALL pulse for one cycle at t+1+SETTLE, and busy SHALL drop in that same cycle.
REQ-021 Press in S_SHOW with busy = 0 SHALL return stage to 0 with no strobe; data and op SHALL hold.
REQ-022 Presses while busy = 1 SHALL be ignored and discarded, not queued.
REQ-023 ld_a, ld_b and ld_f SHALL be mutually exclusive; at most one is high in any cycle.
REQ-024 data SHALL change only in the cycle ld_a or ld_b rises; op SHALL change only on the S_OP press.
REQ-025 The settle counter SHALL not wrap; it stops at zero after the ld_f cycle.
REQ-026 A press coincident with the ld_f cycle SHALL be ignored.

Reset
REQ-027 While rst = 1: data = 0, op = 0, ld_a = ld_b = ld_f = 0, stage = 0, busy = 0, synchronizer and debounced level = 0, all counters = 0.
REQ-028 rst asserted during the settle countdown SHALL cancel the pending ld_f.
REQ-029 After rst deasserts with key held high, one press event SHALL occur once DB_CYCLES stable cycles elapse.

Verification (DB_CYCLES=4, SETTLE=2)
REQ-030 Clean full sequence: press with sw=0x0000_0005, then 0x0000_0003, then 0x1000_0000 -> ld_a with data=5; ld_b with data=3; op=1; ld_f exactly 3 cycles after the op press event; stage 0->1->2->3.
REQ-031 Bounce: key toggles every 2 cycles for 20 cycles, then holds high -> exactly one press event, 4 cycles after the last edge plus synchronizer latency; a single ld_a.
REQ-032 Busy drop: second press event arrives 1 cycle after the op press -> no extra strobe; stage stays 3; the next press after ld_f returns stage to 0.
REQ-033 Reset mid-settle: rst pulse 1 cycle after the op press -> no ld_f ever; all outputs 0; stage 0.
REQ-034 Short glitch: key high for 3 cycles only -> no press event; stage unchanged.
REQ-035 Every cycle: assert at most one of ld_a/ld_b/ld_f is high, each strobe lasts one cycle, and data changes only with ld_a or ld_b.
